// File: rtl/mux_21_pkg.sv
// Shared types and constants for the 2:1 mux arbiter and its datapath.
package mux_21_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } arb_state_t;

   localparam logic SEL_DATA0 = 1'b0;
   localparam logic SEL_DATA1 = 1'b1;

   localparam int DEFAULT_MAX_HOLD = 4;

endpackage

// File: rtl/mux_21.sv
// Registered 2:1 datapath: data_out <= selected input while a grant is live.
// Latency: 1 cycle from grant/selector to data_out/valid_out.
// No backpressure: data_out simply holds its last value when no grant is live.
module mux_21 import mux_21_pkg::*; #(
   parameter int DATA_W = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vld,
   input  logic              selector,
   input  logic [DATA_W-1:0] data_0,
   input  logic [DATA_W-1:0] data_1,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_out  <= '0;
         valid_out <= 1'b0;
      end else begin
         valid_out <= vld;
         if (vld) begin
            data_out <= (selector == SEL_DATA1) ? data_1 : data_0;
         end
      end
   end

endmodule

// File: rtl/mux_21_arbiter.sv
// Two-requester round-robin arbiter driving a registered 2:1 mux.
// Latency: request to grant 1 cycle, grant to data_out 1 more cycle.
// Backpressure: level requests; a held side is forced off after MAX_HOLD cycles if the other waits.
module mux_21_arbiter import mux_21_pkg::*; #(
   parameter int DATA_W   = 1,
   parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_0,
   input  logic              req_1,
   input  logic [DATA_W-1:0] data_0,
   input  logic [DATA_W-1:0] data_1,
   output logic              grant_0,
   output logic              grant_1,
   output logic              selector,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out
);

   localparam int               CNT_W     = $clog2(MAX_HOLD);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   arb_state_t       state;
   arb_state_t       state_nxt;
   logic             last_sel;
   logic [CNT_W-1:0] hold_cnt;
   logic             at_last;

   function automatic arb_state_t arb_next(
      input arb_state_t cur,
      input logic       r0,
      input logic       r1,
      input logic       lsel,
      input logic       hold_done
   );
      arb_state_t nxt;
      nxt = cur;
      case (cur)
         IDLE: begin
            // On a tie, serve whichever side was not served most recently.
            if (r0 && r1)  nxt = (lsel == SEL_DATA1) ? GRANT0 : GRANT1;
            else if (r0)   nxt = GRANT0;
            else if (r1)   nxt = GRANT1;
         end
         GRANT0: begin
            if (!r0)                   nxt = r1 ? GRANT1 : IDLE;
            else if (r1 && hold_done)  nxt = GRANT1;
         end
         GRANT1: begin
            if (!r1)                   nxt = r0 ? GRANT0 : IDLE;
            else if (r0 && hold_done)  nxt = GRANT0;
         end
         default: nxt = IDLE;
      endcase
      return nxt;
   endfunction

   assign at_last   = (hold_cnt == HOLD_LAST);
   assign state_nxt = arb_next(state, req_0, req_1, last_sel, at_last);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         last_sel <= SEL_DATA1;
         hold_cnt <= '0;
         grant_0  <= 1'b0;
         grant_1  <= 1'b0;
         selector <= SEL_DATA0;
      end else begin
         state   <= state_nxt;
         grant_0 <= (state_nxt == GRANT0);
         grant_1 <= (state_nxt == GRANT1);

         if (state_nxt != state) begin
            hold_cnt <= '0;
         end else if (state != IDLE && !at_last) begin
            hold_cnt <= hold_cnt + 1'b1;
         end

         // Selector only moves on a grant, so it holds steady through IDLE.
         if (state_nxt == GRANT0) begin
            selector <= SEL_DATA0;
            last_sel <= SEL_DATA0;
         end else if (state_nxt == GRANT1) begin
            selector <= SEL_DATA1;
            last_sel <= SEL_DATA1;
         end
      end
   end

   mux_21 #(.DATA_W(DATA_W)) u_mux (
      .clk       (clk),
      .reset     (reset),
      .vld       (grant_0 | grant_1),
      .selector  (selector),
      .data_0    (data_0),
      .data_1    (data_1),
      .data_out  (data_out),
      .valid_out (valid_out)
   );

endmodule

// File: doc/mux_21_arbiter.md
# mux_21_arbiter

Two-requester round-robin arbiter that owns the `selector` of the 2:1 mux and registers its output. It sits in front of the `mux_21` datapath and replaces the free-running tester stimulus with a request/grant handshake. A bounded hold count keeps one requester from starving the other.

## Interface
Parameters:
- `DATA_W`, default 1: width of `data_0`, `data_1` and `data_out`.
- `MAX_HOLD`, default 4: maximum consecutive grant cycles while the other side is requesting. Legal range is at least 2.

Ports:
- `clk` in 1: single clock; all state changes on its posedge.
- `reset` in 1: asynchronous, active-low. Low clears all state immediately, independent of `clk`.
- `req_0` in 1: requester 0 wants the mux.
- `req_1` in 1: requester 1 wants the mux.
- `data_0` in `DATA_W`: requester 0 data.
- `data_1` in `DATA_W`: requester 1 data.
- `grant_0` out 1: registered; requester 0 owns the mux this cycle.
- `grant_1` out 1: registered; requester 1 owns the mux this cycle.
- `selector` out 1: registered; 0 selects `data_0`, 1 selects `data_1`.
- `data_out` out `DATA_W`: registered mux output.
- `valid_out` out 1: `data_out` holds granted data.

## Operation
- States:
  - `IDLE`: no grant.
  - `GRANT0`: `grant_0`=1, `selector`=0.
  - `GRANT1`: `grant_1`=1, `selector`=1.
- `last_sel` register records the most recently served side. It resets to 1, so requester 0 wins the first tie.
- `hold_cnt` is `$clog2(MAX_HOLD)` bits. It clears on every entry to a GRANT state, increments each cycle the grant is kept, and saturates at `MAX_HOLD-1`.
- Transitions from `IDLE`:
  - Both `req_0` and `req_1` high: grant the side ≠ `last_sel`.
  - Only one request high: grant that side.
  - No request: stay in `IDLE`.
- Transitions from `GRANTk`:
  - `req_k`=0 and other request high: go directly to the other GRANT state. No bubble.
  - `req_k`=0 and other request low: go to `IDLE`.
  - `req_k`=1, other request high, and `hold_cnt`==`MAX_HOLD-1`: forced switch to the other side.
  - `req_k`=1 otherwise: stay; `hold_cnt` saturates.
- `last_sel` updates to k on every entry to `GRANTk`.
- `selector` holds its last value in `IDLE`, so the mux does not glitch.
- Datapath: each cycle `data_out` ← (`selector`? `data_1` : `data_0`) and `valid_out` ← `grant_0` | `grant_1`. Values are taken from the registered grant/selector.
- `data_out` holds its value when `valid_out`=0.
- `grant_0` and `grant_1` are never both 1.

## Timing
- Reset values:
  - state `IDLE`, `last_sel`=1, `hold_cnt`=0.
  - `grant_0`=0, `grant_1`=0, `selector`=0.
  - `data_out`=0, `valid_out`=0.
- Request to grant: a request seen at posedge N gives a grant high after posedge N (1-cycle latency).
- Grant to data: data sampled while the grant is high at posedge N+1 appears on `data_out` with `valid_out`=1 after posedge N+1.
- Request release: the grant drops the cycle after the request drops. `valid_out` drops one cycle later.
- Handoff: one cycle between the releasing edge and the new grant. `valid_out` stays continuously high across the handoff.
- Forced switch: with both requests held, each side gets exactly `MAX_HOLD` consecutive grant cycles, alternating.
- Reset asserted mid-grant: outputs clear asynchronously. After release, arbitration restarts with requester 0 favoured.
- Requests are level-sensitive. A requester must hold its request until it sees its grant; a drop before then is simply not served.

## Structure
- Shared package `mux_21_pkg` holds:
  - state enum `arb_state_t` (`IDLE`, `GRANT0`, `GRANT1`),
  - `SEL_DATA0`=0 and `SEL_DATA1`=1,
  - default `MAX_HOLD`.
- One sub-module, `mux_21`, is the registered 2:1 datapath (`selector`, `data_0`, `data_1` → `data_out`, `valid_out`). It is instantiated once.
- The FSM, `hold_cnt` and `last_sel` stay in the top level.

## Test plan
Tests use `DATA_W`=8 and `MAX_HOLD`=4.
- Reset: drive `reset`=0 mid-cycle with `req_0`=1 → all outputs 0 immediately. After release, `grant_0`=1 one cycle later.
- Single requester: `req_1`=1 for 3 cycles, `data_1`=8'hA5 → `grant_1`=1 for 3 cycles; `data_out`=8'hA5 with `valid_out`=1 for 3 cycles, lagging the grant by 1.
- Tie after reset: `req_0`=`req_1`=1 together → `grant_0` first for 4 cycles, then `grant_1` for 4 cycles, repeating. `valid_out` never drops.
- Early release: in `GRANT0` at `hold_cnt`=1, drop `req_0` with `req_1`=1 → `grant_1` rises on the next cycle with no idle gap; `hold_cnt` restarts at 0.
- Idle hold: `GRANT1` ends with both requests low → `IDLE`, `selector` stays 1, `data_out` unchanged, `valid_out`=0.
- No contention: `req_0` held for 10 cycles, `req_1`=0 → `grant_0` stays high for all 10; no forced switch.
